// File: rtl/huffman_encoder.sv
// huffman_encoder
//   Encodes 4-bit symbols with the fixed prefix code (lengths 1/4/5/6/10).
//   The code bits are packed MSB-first into OUT_W-bit words. A flush request
//   zero-pads the last partial word, and that word is marked with out_last.
//
// Parameters
//   OUT_W       output word width (8..16)
//   ACC_W       bit accumulator width (must be >= OUT_W+9)
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   sym_in/sym_valid/sym_ready   symbol input handshake
//   flush                        one-cycle drain request
//   out_data/out_valid/out_ready packed word output handshake
//   out_last                     marks the zero-padded final word of a flush
//   flush_done                   one-cycle pulse when a flush completes
//   sym_count, bit_count         statistics counters; present only when
//                                HUFF_ENC_STATS_EN is defined
//
// State table
//   state   | meaning
//   S_RUN   | accepting symbols, popping full words
//   S_FLUSH | no symbol intake; draining full words, then the padded tail
module huffman_encoder #(
  parameter int OUT_W = 8,
  parameter int ACC_W = OUT_W + 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             flush_done
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [15:0]      sym_count,
  output logic [19:0]      bit_count
`endif
);

  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(OUT_W);
  // Room for the longest (10-bit) code must remain before a symbol is taken.
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ACC_W - 10);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               flush_done_q, flush_done_d;
  logic               sym_ready_q, sym_ready_d;

  logic [9:0]         code_r;
  logic [3:0]         code_len;
  logic [9:0]         code_l;
  logic [ACC_W-1:0]   code_top;

  // Code lookup: right-aligned code value plus its length.
  always_comb begin
    code_r   = '0;
    code_len = 4'd1;
    if (sym_in == 4'd0) begin
      code_r   = '0;
      code_len = 4'd1;
    end else if (sym_in <= 4'd5) begin
      code_r   = 10'(sym_in) + 10'd7;     // 1 -> 1000
      code_len = 4'd4;
    end else if (sym_in <= 4'd8) begin
      code_r   = 10'(sym_in) + 10'd20;    // 6 -> 11010
      code_len = 4'd5;
    end else if (sym_in <= 4'd13) begin
      code_r   = 10'(sym_in) + 10'd49;    // 9 -> 111010
      code_len = 4'd6;
    end else begin
      code_r   = 10'(sym_in) + 10'd994;   // 14 -> 1111110000
      code_len = 4'd10;
    end
  end

  // Left-align the code so it can be shifted down to the fill position.
  assign code_l   = code_r << (4'd10 - code_len);
  assign code_top = {code_l, {(ACC_W-10){1'b0}}};

  logic             accept, out_free, pop, pad, fl_end;
  logic [ACC_W-1:0] acc_base;
  logic [FILL_W-1:0] fill_base;

  always_comb begin
    accept   = sym_valid && sym_ready_q;
    out_free = !out_valid_q || out_ready;
    pop      = (fill_q >= FILL_OUT) && out_free;
    pad      = (state_q == S_FLUSH) && (fill_q != '0) && (fill_q < FILL_OUT) && out_free;
    fl_end   = (state_q == S_FLUSH) && ((fill_q == '0) || pad);

    // Pop (or tail drain) uses the pre-append contents; the new code lands
    // behind whatever remains afterwards.
    acc_base  = acc_q;
    fill_base = fill_q;
    if (pop) begin
      acc_base  = acc_q << OUT_W;
      fill_base = fill_q - FILL_OUT;
    end else if (pad) begin
      acc_base  = '0;
      fill_base = '0;
    end

    acc_d  = acc_base;
    fill_d = fill_base;
    if (accept) begin
      acc_d  = acc_base | (code_top >> fill_base);
      fill_d = fill_base + FILL_W'(code_len);
    end

    // Bits below fill are always zero, so the tail word is already padded.
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (pop || pad) begin
      out_data_d  = acc_q[ACC_W-1 -: OUT_W];
      out_valid_d = 1'b1;
      out_last_d  = pad;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush)  state_d = S_FLUSH;
      S_FLUSH: if (fl_end) state_d = S_RUN;
      default:             state_d = S_RUN;
    endcase

    flush_done_d = fl_end;
    sym_ready_d  = (state_d == S_RUN) && (fill_d <= FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
      sym_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
      sym_ready_q  <= sym_ready_d;
    end
  end

  assign sym_ready  = sym_ready_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign flush_done = flush_done_q;

`ifdef HUFF_ENC_STATS_EN
  logic [15:0] sym_cnt_q;
  logic [19:0] bit_cnt_q;

  // Padding is never counted: only accepted code bits add to bit_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      sym_cnt_q <= sym_cnt_q + 16'd1;
      bit_cnt_q <= bit_cnt_q + 20'(code_len);
    end
  end

  assign sym_count = sym_cnt_q;
  assign bit_count = bit_cnt_q;
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
module tb_huffman_encoder;
  localparam int OUT_W = 8;
  localparam int ACC_W = OUT_W + 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       sym_in = '0;
  logic             sym_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b1;
  logic             sym_ready, out_valid, out_last, flush_done;
  logic [OUT_W-1:0] out_data;
`ifdef HUFF_ENC_STATS_EN
  logic [15:0]      sym_count;
  logic [19:0]      bit_count;
`endif

  huffman_encoder #(.OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .flush_done(flush_done)
`ifdef HUFF_ENC_STATS_EN
    , .sym_count(sym_count), .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  string CODES [16] = '{"0", "1000", "1001", "1010", "1011", "1100",
                        "11010", "11011", "11100",
                        "111010", "111011", "111100", "111101", "111110",
                        "1111110000", "1111110001"};

  bit          model_bits[$];   // bits accepted but not yet seen on the output
  int unsigned pushed, consumed;
  int unsigned bounds[$];       // bit positions where a flush cuts the stream
  bit          pending;
  int unsigned sc, bc;

  logic [OUT_W-1:0] log_data[$];
  bit               log_last[$];

  bit               prev_stall;
  logic [OUT_W-1:0] prev_data;
  logic             prev_last;
  logic [OUT_W-1:0] mw;
  int               avail, nb;

  always @(negedge clk) begin
    if (rst) begin
      model_bits.delete(); bounds.delete();
      pushed = 0; consumed = 0; pending = 0; prev_stall = 0; sc = 0; bc = 0;
    end else begin
`ifdef HUFF_ENC_STATS_EN
      chk("sym_count", 32'(sym_count), 32'(sc[15:0]));
      chk("bit_count", 32'(bit_count), 32'(bc[19:0]));
`endif
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (flush_done) begin
        chk("done_without_flush", 32'(pending), 32'd1);
        pending = 0;
      end else if (pending) begin
        chk("ready_during_flush", 32'(sym_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        avail = (bounds.size() > 0) ? int'(bounds[0] - consumed) : model_bits.size();
        if (avail >= OUT_W || (bounds.size() > 0 && avail > 0)) begin
          nb = (avail >= OUT_W) ? OUT_W : avail;
          mw = '0;
          for (int b = 0; b < nb; b++) mw[OUT_W-1-b] = model_bits[b];
          for (int b = 0; b < nb; b++) void'(model_bits.pop_front());
          consumed += nb;
          chk("word_data", 32'(out_data), 32'(mw));
          chk("word_last", 32'(out_last), 32'(nb < OUT_W));
          while (bounds.size() > 0 && bounds[0] == consumed) void'(bounds.pop_front());
        end else begin
          checks++; errors++;
          $display("FAIL spurious_word: got data 0x%0h last %0d, required no word", out_data, out_last);
        end
        log_data.push_back(out_data);
        log_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (sym_valid && sym_ready) begin
        for (int c = 0; c < CODES[sym_in].len(); c++)
          model_bits.push_back(CODES[sym_in].getc(c) == "1");
        pushed += CODES[sym_in].len();
        sc++;
        bc += CODES[sym_in].len();
      end
      if (flush && !pending) begin
        pending = 1;
        bounds.push_back(pushed);
        while (bounds.size() > 0 && bounds[0] == consumed) void'(bounds.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] s);
    bit got = 0;
    sym_in = s; sym_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); got = sym_ready;
      step();
      if (got) break;
    end
    sym_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: sym_ready stayed 0, required 1");
    end
  endtask

  task automatic do_flush();
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic wait_done(input bit exp_last, input string nm);
    bit seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (flush_done) begin seen = 1; break; end
    end
    chk({nm, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_last"}, 32'(out_last), 32'(exp_last));
      if (exp_last) chk({nm, "_lastvalid"}, 32'(out_valid), 32'd1);
    end
    step();
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(flush_done), 32'd0);
    step();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [OUT_W-1:0] d, input bit l);
    if (idx < log_data.size()) begin
      chk({nm, "_data"}, 32'(log_data[idx]), 32'(d));
      chk({nm, "_last"}, 32'(log_last[idx]), 32'(l));
    end else begin
      checks++; errors++;
      $display("FAIL %s: word %0d missing, required 0x%0h", nm, idx, d);
    end
  endtask

  task automatic clr_log();
    log_data.delete(); log_last.delete();
  endtask

  int n, nvalid, nlast;
  bit got;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    step(); step();
    @(negedge clk);
    chk("rst_sym_ready", 32'(sym_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_ready", 32'(sym_ready), 32'd1);
    step();

    // eight zeros back to back -> 0x00, one cycle after the 8th accept
    clr_log();
    sym_in = 4'd0; sym_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_ready", 32'(sym_ready), 32'd1);
      step();
    end
    sym_valid = 1'b0;
    @(negedge clk);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h00);
    chk("t1_last", 32'(out_last), 32'd0);
    step();

    // 1,2 -> 0x89 ; 9,6 + flush -> 0xEB, 0x40 (last)
    clr_log();
    send(4'd1); send(4'd2); send(4'd9); send(4'd6);
    do_flush();
    wait_done(1'b1, "t2");
    repeat (4) step();
    chk("t2_count", 32'(log_data.size()), 32'd3);
    chk_log("t2_w0", 0, 8'h89, 1'b0);
    chk_log("t2_w1", 1, 8'hEB, 1'b0);
    chk_log("t2_w2", 2, 8'h40, 1'b1);

    // 14 + flush -> 0xFC, 0x00 (last)
    clr_log();
    send(4'd14);
    do_flush();
    wait_done(1'b1, "t3");
    repeat (4) step();
    chk("t3_count", 32'(log_data.size()), 32'd2);
    chk_log("t3_w0", 0, 8'hFC, 1'b0);
    chk_log("t3_w1", 1, 8'h00, 1'b1);

    // flush on a word boundary: no padded word, flush_done still pulses
    clr_log();
    send(4'd1); send(4'd2);
    do_flush();
    wait_done(1'b0, "t4");
    repeat (4) step();
    chk("t4_count", 32'(log_data.size()), 32'd1);
    chk_log("t4_w0", 0, 8'h89, 1'b0);

    // stall with symbol 15 streamed: sym_ready drops after three accepts
    clr_log();
    out_ready = 1'b0;
    sym_in = 4'd15; sym_valid = 1'b1; n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!sym_ready) break;
      n++;
      step();
    end
    chk("t5_accepts", 32'(n), 32'd3);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_ready", 32'(sym_ready), 32'd0);
      chk("t5_stall_data", 32'(out_data), 32'hFC);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 200 && n < 8; k++) begin
      @(negedge clk); got = sym_ready;
      step();
      if (got) n++;
    end
    sym_valid = 1'b0;
    chk("t5_total", 32'(n), 32'd8);
    do_flush();
    wait_done(1'b0, "t5");
    repeat (4) step();
    chk("t5_count", 32'(log_data.size()), 32'd10);
    chk_log("t5_w0", 0, 8'hFC, 1'b0);
    chk_log("t5_w1", 1, 8'h7F, 1'b0);
    chk_log("t5_w2", 2, 8'h1F, 1'b0);
    chk_log("t5_w3", 3, 8'hC7, 1'b0);

    // reset while flushing with a stalled output word
    clr_log();
    out_ready = 1'b0;
    send(4'd1); send(4'd2); send(4'd3);
    do_flush();
    step(); step();
    @(negedge clk);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_data", 32'(out_data), 32'h89);
    chk("t6_pre_done", 32'(flush_done), 32'd0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(sym_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t6_after_ready", 32'(sym_ready), 32'd1);
    chk("t6_after_valid", 32'(out_valid), 32'd0);
    step();
    out_ready = 1'b1;
    nvalid = 0; nlast = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
      if (out_last || flush_done) nlast++;
      step();
    end
    chk("t6_no_valid", 32'(nvalid), 32'd0);
    chk("t6_no_last", 32'(nlast), 32'd0);
    send(4'd1); send(4'd2);
    repeat (4) step();
    chk("t6_count", 32'(log_data.size()), 32'd1);
    chk_log("t6_w0", 0, 8'h89, 1'b0);

`ifdef HUFF_ENC_STATS_EN
    // statistics: 0, 5, 14 -> 3 symbols, 15 bits; flush leaves bit_count alone
    rst = 1'b1; step(); rst = 1'b0; step();
    send(4'd0); send(4'd5); send(4'd14);
    step();
    @(negedge clk);
    chk("st_sym_count", 32'(sym_count), 32'd3);
    chk("st_bit_count", 32'(bit_count), 32'd15);
    step();
    do_flush();
    wait_done(1'b1, "st");
    @(negedge clk);
    chk("st_bit_after_flush", 32'(bit_count), 32'd15);
    chk("st_sym_after_flush", 32'(sym_count), 32'd3);
    step();
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
# huffman_encoder

- Encodes a stream of 4-bit symbols with the team's fixed prefix code (lengths 1/4/5/6/10).
- Packs the code bits MSB-first into OUT_W-bit words, with a valid/ready handshake on both sides.
- Sits upstream of huffman_decoder and produces the bitstream that the decoder consumes.
- A flush command zero-pads and emits the final partial word.

## Interface
- OUT_W, 8, output word width in bits (8..16).
- ACC_W, OUT_W+16, width of the bit accumulator; must be ≥ OUT_W+9.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sym_in  in  4  symbol to encode.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  encoder accepts sym_in this cycle.
- flush  in  1  one-cycle request to drain the accumulator.
- out_data  out  OUT_W  packed bits; the first-coded bit is in the MSB.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the final padded word of a flush.
- flush_done  out  1  one-cycle pulse when a flush completes.

## Operation
Code table (symbol -> code):
- Symbol 0 -> 0.
- Symbols 1..5 -> 1000, 1001, 1010, 1011, 1100.
- Symbols 6..8 -> 11010, 11011, 11100.
- Symbols 9..13 -> 111010, 111011, 111100, 111101, 111110.
- Symbols 14, 15 -> 1111110000, 1111110001.

Accumulator and fill count:
- acc[ACC_W-1:0] holds the pending bits left-aligned; fill (0..ACC_W) is the number of valid bits.
- Accept condition: sym_valid && sym_ready. The code is appended at bit position fill from the MSB, and fill increases by the code length.
- Pop condition: fill ≥ OUT_W && (!out_valid || out_ready). On a pop, the top OUT_W bits load into out_data, acc shifts left by OUT_W, and fill decreases by OUT_W.
- Accept and pop in the same cycle: the pop takes the pre-append top bits. Then fill_next = fill + len − (pop ? OUT_W : 0).
- sym_ready = (state==RUN) && (fill ≤ ACC_W−10), evaluated from registers only (no combinational path from sym_valid).
- Output register hold: while out_valid && !out_ready, out_data and out_last stay stable. out_valid clears on handshake unless a new pop occurs in the same cycle.

State machine:
- RUN → FLUSH when flush=1. A symbol accepted in the same cycle is included in the flush.
- FLUSH: sym_ready=0. Full words keep popping normally.
  - fill == 0: go to RUN and pulse flush_done.
  - 0 < fill < OUT_W and the output register is free: load the remaining bits followed by zero padding, set out_last=1, fill→0, go to RUN, and pulse flush_done in that same cycle.
- flush asserted while already in FLUSH is ignored.
- If fill is a multiple of OUT_W at flush time, no padded word is produced and out_last is never asserted for that flush. flush_done still pulses.

## Timing
- Reset values: sym_ready=0 during reset, then 1 on the first cycle after (RUN, fill=0). out_valid=0, out_data=0, out_last=0, flush_done=0; acc, fill and counters are 0.
- Latency: a symbol accepted at edge N whose bits complete a word gives out_valid=1 after edge N+1.
- Sustained throughput: one symbol per cycle while fill ≤ ACC_W−10 and downstream keeps up. Symbols longer than OUT_W bits per cycle throttle through sym_ready.
- Reset mid-operation (including mid-flush): all pending bits are discarded, no out_last is issued, and the block returns to RUN the cycle after rst drops.

## Configuration
- HUFF_ENC_STATS_EN defined: adds output ports sym_count[15:0] and bit_count[19:0].
  - sym_count increments per accepted symbol; bit_count increments by code length (padding excluded).
  - Both wrap modulo 2^16 and 2^20, clear on rst, and are unaffected by flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
All cases use OUT_W=8 unless stated.
- Eight symbol 0s back-to-back → one word 0x00. out_valid rises one cycle after the 8th accept; out_last=0.
- Symbols 1, 2 → 0x89. Then symbols 9, 6 followed by flush → 0xEB (11101011) and 0x40 (010 + pad) with out_last=1 and flush_done=1.
- Symbol 14 then flush → 0xFC, then 0x00 with out_last=1.
- out_ready held low, symbol 15 streamed continuously → sym_ready drops once fill > 14. Release out_ready → words 0xFC, 0x7F, 0x1F, … with no bit lost or duplicated; out_data stays stable while stalled.
- rst pulsed during FLUSH with out_valid=1 → next cycle out_valid=0, fill=0, sym_ready=1, no out_last ever issued.
- With HUFF_ENC_STATS_EN: symbols 0, 5, 14 → sym_count=3, bit_count=15. After flush, bit_count remains 15.
